// File: rtl/ras_predictor_pkg.sv
// RISC-V definitions shared by the return-address-stack predictor:
// control-transfer opcodes and the link-register convention.
package ras_predictor_pkg;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   // x1 (ra) and x5 (t0) are both treated as link registers.
   localparam logic [4:0] REG_RA = 5'd1;
   localparam logic [4:0] REG_T0 = 5'd5;

   function automatic logic is_link(input logic [4:0] r);
      return (r == REG_RA) || (r == REG_T0);
   endfunction

endpackage

// File: rtl/ras_predictor_decode.sv
// Classifies a qualified control-transfer instruction into push / pop
// requests; push and pop together mean pop-then-push (coroutine swap).
module ras_decode
   import ras_predictor_pkg::*;
(
   input  logic       valid,
   input  logic [6:0] opcode,
   input  logic [4:0] rd,
   input  logic [4:0] rs1,
   output logic       push,
   output logic       pop
);

   logic rd_link;
   logic rs1_link;

   assign rd_link  = is_link(rd);
   assign rs1_link = is_link(rs1);

   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      if (valid) begin
         case (opcode)
            OP_JAL: push = rd_link;
            OP_JALR: begin
               case ({rd_link, rs1_link})
                  2'b10: push = 1'b1;
                  2'b01: pop  = 1'b1;
                  2'b11: begin
                     push = 1'b1;
                     pop  = (rd != rs1);
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ras_predictor.sv
// Circular return-address stack with sticky overflow/underflow flags and
// checkpoint/restore of the stack pointer and occupancy.
module ras_predictor
   import ras_predictor_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   // valid_i qualifies one instruction per cycle; there is no back-pressure,
   // so every valid cycle is consumed and answered on the following cycle.
   input  logic            valid_i,
   input  logic [6:0]      opcode_i,
   input  logic [4:0]      rd_i,
   input  logic [4:0]      rs1_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            restore_i,
   input  logic [PW-1:0]   restore_tos_i,
   input  logic [PW:0]     restore_cnt_i,
   output logic            pred_valid_o,
   output logic [XLEN-1:0] pred_pc_o,
   output logic [PW-1:0]   ckpt_tos_o,
   output logic [PW:0]     ckpt_cnt_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            ovf_o,
   output logic            unf_o
);

   localparam logic [PW-1:0]   TOS_ONE     = PW'(1);
   localparam logic [PW-1:0]   TOS_RESET   = PW'(DEPTH - 1);
   localparam logic [PW:0]     CNT_ONE     = (PW + 1)'(1);
   localparam logic [PW:0]     CNT_FULL    = (PW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

   logic [XLEN-1:0] entries [DEPTH];
   logic [PW-1:0]   tos;
   logic [PW:0]     cnt;
   logic            push;
   logic            pop;
   logic            not_empty;
   logic [PW-1:0]   tos_inc;
   logic [PW-1:0]   tos_dec;
   logic [XLEN-1:0] rd_data;
   logic            wr_en;
   logic [PW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   ras_decode u_decode (
      .valid  (valid_i),
      .opcode (opcode_i),
      .rd     (rd_i),
      .rs1    (rs1_i),
      .push   (push),
      .pop    (pop)
   );

   assign not_empty = (cnt != '0);
   assign tos_inc   = tos + TOS_ONE;
   assign tos_dec   = tos - TOS_ONE;
   assign rd_data   = entries[tos];

   // A successful pop-then-push reuses the slot just read instead of advancing.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = tos_inc;
      wr_data = pc_i + INSTR_BYTES;
      if (!rst && !restore_i && push) begin
         wr_en   = 1'b1;
         wr_addr = (pop && not_empty) ? tos : tos_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         entries[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tos          <= TOS_RESET;
         cnt          <= '0;
         pred_valid_o <= 1'b0;
         pred_pc_o    <= '0;
         ovf_o        <= 1'b0;
         unf_o        <= 1'b0;
      end else if (restore_i) begin
         tos          <= restore_tos_i;
         cnt          <= restore_cnt_i;
         pred_valid_o <= 1'b0;
      end else begin
         pred_valid_o <= 1'b0;
         if (pop && !push) begin
            if (not_empty) begin
               pred_valid_o <= 1'b1;
               pred_pc_o    <= rd_data;
               tos          <= tos_dec;
               cnt          <= cnt - CNT_ONE;
            end else begin
               unf_o <= 1'b1;
            end
         end else if (pop && push) begin
            if (not_empty) begin
               pred_valid_o <= 1'b1;
               pred_pc_o    <= rd_data;
            end else begin
               // Nothing to pop: record the underflow, the push still lands.
               unf_o <= 1'b1;
               tos   <= tos_inc;
               cnt   <= cnt + CNT_ONE;
            end
         end else if (push) begin
            tos <= tos_inc;
            if (cnt == CNT_FULL) begin
               ovf_o <= 1'b1;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end
      end
   end

   assign ckpt_tos_o = tos;
   assign ckpt_cnt_o = cnt;
   assign empty_o    = (cnt == '0);
   assign full_o     = (cnt == CNT_FULL);

endmodule

// File: tb/tb_ras_predictor.sv
// Directed bench for ras_predictor (DEPTH=8, XLEN=32): call/return, overflow
// wrap, coroutine swap, checkpoint restore, reset priority and no-op decodes.
module tb_ras_predictor;

   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ADDI = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic [6:0]  opcode_i = '0;
   logic [4:0]  rd_i = '0;
   logic [4:0]  rs1_i = '0;
   logic [31:0] pc_i = '0;
   logic        restore_i = 1'b0;
   logic [2:0]  restore_tos_i = '0;
   logic [3:0]  restore_cnt_i = '0;
   logic        pred_valid_o;
   logic [31:0] pred_pc_o;
   logic [2:0]  ckpt_tos_o;
   logic [3:0]  ckpt_cnt_o;
   logic        empty_o;
   logic        full_o;
   logic        ovf_o;
   logic        unf_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   ras_predictor #(.DEPTH(8), .XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_i       (valid_i),
      .opcode_i      (opcode_i),
      .rd_i          (rd_i),
      .rs1_i         (rs1_i),
      .pc_i          (pc_i),
      .restore_i     (restore_i),
      .restore_tos_i (restore_tos_i),
      .restore_cnt_i (restore_cnt_i),
      .pred_valid_o  (pred_valid_o),
      .pred_pc_o     (pred_pc_o),
      .ckpt_tos_o    (ckpt_tos_o),
      .ckpt_cnt_o    (ckpt_cnt_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .ovf_o         (ovf_o),
      .unf_o         (unf_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid_i   = 1'b0;
      restore_i = 1'b0;
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
   endtask

   task automatic drive_op(input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [31:0] pc);
      valid_i  = 1'b1;
      opcode_i = op;
      rd_i     = rd;
      rs1_i    = rs1;
      pc_i     = pc;
      tick();
      valid_i  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vec_cnt++;
      if ({ckpt_tos_o, ckpt_cnt_o} !== {3'd7, 4'd0}) begin
         err_cnt++;
         $display("FAIL reset_ptr got tos=%0d cnt=%0d exp tos=7 cnt=0", ckpt_tos_o, ckpt_cnt_o);
      end
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o} !== {1'b0, 32'h0}) begin
         err_cnt++;
         $display("FAIL reset_pred got v=%b pc=%h exp v=0 pc=0", pred_valid_o, pred_pc_o);
      end
      vec_cnt++;
      if ({empty_o, full_o, ovf_o, unf_o} !== 4'b1000) begin
         err_cnt++;
         $display("FAIL reset_flags got %b exp 1000", {empty_o, full_o, ovf_o, unf_o});
      end
   endtask

   task automatic test_call_return();
      do_reset();
      drive_op(JAL, 5'd1, 5'd0, 32'h100);
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd0, 4'd1}) begin
         err_cnt++;
         $display("FAIL call_push got v=%b tos=%0d cnt=%0d exp v=0 tos=0 cnt=1",
                  pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(JALR, 5'd0, 5'd1, 32'h500);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o} !== {1'b1, 32'h104}) begin
         err_cnt++;
         $display("FAIL return_pred got v=%b pc=%h exp v=1 pc=00000104", pred_valid_o, pred_pc_o);
      end
      vec_cnt++;
      if ({ckpt_tos_o, ckpt_cnt_o, empty_o} !== {3'd7, 4'd0, 1'b1}) begin
         err_cnt++;
         $display("FAIL return_ptr got tos=%0d cnt=%0d empty=%b exp 7 0 1",
                  ckpt_tos_o, ckpt_cnt_o, empty_o);
      end
      tick();
      vec_cnt++;
      if (pred_valid_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL pred_one_cycle got %b exp 0", pred_valid_o);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive_op(JAL, 5'd1, 5'd0, 32'h10 * i);
         if (i == 7) begin
            vec_cnt++;
            if ({full_o, ovf_o, ckpt_cnt_o} !== {1'b1, 1'b0, 4'd8}) begin
               err_cnt++;
               $display("FAIL fill_8 got full=%b ovf=%b cnt=%0d exp 1 0 8", full_o, ovf_o, ckpt_cnt_o);
            end
         end
      end
      vec_cnt++;
      if ({full_o, ovf_o, ckpt_cnt_o, ckpt_tos_o} !== {1'b1, 1'b1, 4'd8, 3'd0}) begin
         err_cnt++;
         $display("FAIL push_9 got full=%b ovf=%b cnt=%0d tos=%0d exp 1 1 8 0",
                  full_o, ovf_o, ckpt_cnt_o, ckpt_tos_o);
      end
      for (int k = 0; k < 8; k++) begin
         exp_pc = 32'h84 - 32'h10 * k;
         drive_op(JALR, 5'd0, 5'd1, 32'h900);
         vec_cnt++;
         if ({pred_valid_o, pred_pc_o} !== {1'b1, exp_pc}) begin
            err_cnt++;
            $display("FAIL ovf_pop[%0d] got v=%b pc=%h exp v=1 pc=%h", k, pred_valid_o, pred_pc_o, exp_pc);
         end
      end
      drive_op(JALR, 5'd0, 5'd1, 32'h900);
      vec_cnt++;
      if ({pred_valid_o, unf_o, ovf_o, empty_o, ckpt_tos_o, ckpt_cnt_o} !==
          {1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd0}) begin
         err_cnt++;
         $display("FAIL underflow got v=%b unf=%b ovf=%b empty=%b tos=%0d cnt=%0d exp 0 1 1 1 0 0",
                  pred_valid_o, unf_o, ovf_o, empty_o, ckpt_tos_o, ckpt_cnt_o);
      end
   endtask

   task automatic test_coroutine();
      do_reset();
      drive_op(JAL, 5'd1, 5'd0, 32'h200);
      drive_op(JALR, 5'd1, 5'd5, 32'h300);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o, ckpt_cnt_o, ckpt_tos_o} !== {1'b1, 32'h204, 4'd1, 3'd0}) begin
         err_cnt++;
         $display("FAIL coroutine_swap got v=%b pc=%h cnt=%0d tos=%0d exp 1 00000204 1 0",
                  pred_valid_o, pred_pc_o, ckpt_cnt_o, ckpt_tos_o);
      end
      drive_op(JALR, 5'd0, 5'd1, 32'h400);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o, ckpt_cnt_o} !== {1'b1, 32'h304, 4'd0}) begin
         err_cnt++;
         $display("FAIL coroutine_pop got v=%b pc=%h cnt=%0d exp 1 00000304 0",
                  pred_valid_o, pred_pc_o, ckpt_cnt_o);
      end
   endtask

   task automatic test_restore();
      do_reset();
      drive_op(JAL, 5'd1, 5'd0, 32'h1000);
      drive_op(JAL, 5'd5, 5'd0, 32'h2000);
      vec_cnt++;
      if ({ckpt_tos_o, ckpt_cnt_o} !== {3'd1, 4'd2}) begin
         err_cnt++;
         $display("FAIL ckpt_view got tos=%0d cnt=%0d exp 1 2", ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(JAL, 5'd1, 5'd0, 32'h3000);
      drive_op(JAL, 5'd1, 5'd0, 32'h4000);
      drive_op(JAL, 5'd1, 5'd0, 32'h5000);
      restore_i     = 1'b1;
      restore_tos_i = 3'd1;
      restore_cnt_i = 4'd2;
      // A concurrent push must be ignored while restoring.
      drive_op(JAL, 5'd1, 5'd0, 32'h6000);
      restore_i     = 1'b0;
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd1, 4'd2}) begin
         err_cnt++;
         $display("FAIL restore_ptr got v=%b tos=%0d cnt=%0d exp 0 1 2",
                  pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(JALR, 5'd0, 5'd1, 32'h7000);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o} !== {1'b1, 32'h2004}) begin
         err_cnt++;
         $display("FAIL restore_pop got v=%b pc=%h exp 1 00002004", pred_valid_o, pred_pc_o);
      end
   endtask

   task automatic test_reset_with_push();
      do_reset();
      drive_op(JAL, 5'd1, 5'd0, 32'h40);
      rst = 1'b1;
      drive_op(JAL, 5'd1, 5'd0, 32'h80);
      rst = 1'b0;
      vec_cnt++;
      if ({ckpt_cnt_o, empty_o, pred_valid_o, ckpt_tos_o} !== {4'd0, 1'b1, 1'b0, 3'd7}) begin
         err_cnt++;
         $display("FAIL rst_push got cnt=%0d empty=%b v=%b tos=%0d exp 0 1 0 7",
                  ckpt_cnt_o, empty_o, pred_valid_o, ckpt_tos_o);
      end
      drive_op(JALR, 5'd0, 5'd1, 32'h0);
      vec_cnt++;
      if ({pred_valid_o, unf_o} !== 2'b01) begin
         err_cnt++;
         $display("FAIL rst_push_pop got v=%b unf=%b exp v=0 unf=1", pred_valid_o, unf_o);
      end
   endtask

   task automatic test_no_action();
      do_reset();
      drive_op(JAL, 5'd1, 5'd0, 32'h40);
      drive_op(JAL, 5'd0, 5'd0, 32'h50);
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd0, 4'd1}) begin
         err_cnt++;
         $display("FAIL jal_x0 got v=%b tos=%0d cnt=%0d exp 0 0 1", pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(ADDI, 5'd1, 5'd1, 32'h60);
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd0, 4'd1}) begin
         err_cnt++;
         $display("FAIL addi got v=%b tos=%0d cnt=%0d exp 0 0 1", pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(JALR, 5'd2, 5'd3, 32'h70);
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd0, 4'd1}) begin
         err_cnt++;
         $display("FAIL jalr_nolink got v=%b tos=%0d cnt=%0d exp 0 0 1", pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      opcode_i = JALR;
      rd_i     = 5'd0;
      rs1_i    = 5'd1;
      tick();
      vec_cnt++;
      if ({pred_valid_o, ckpt_tos_o, ckpt_cnt_o} !== {1'b0, 3'd0, 4'd1}) begin
         err_cnt++;
         $display("FAIL invalid_pop got v=%b tos=%0d cnt=%0d exp 0 0 1", pred_valid_o, ckpt_tos_o, ckpt_cnt_o);
      end
      drive_op(JALR, 5'd0, 5'd5, 32'h80);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o} !== {1'b1, 32'h44}) begin
         err_cnt++;
         $display("FAIL noop_survivor got v=%b pc=%h exp 1 00000044", pred_valid_o, pred_pc_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_op(JALR, 5'd5, 5'd5, 32'hFFFF_FFFC);
      drive_op(JALR, 5'd0, 5'd5, 32'h10);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o, ckpt_cnt_o} !== {1'b1, 32'h0, 4'd0}) begin
         err_cnt++;
         $display("FAIL wrap_pc got v=%b pc=%h cnt=%0d exp 1 00000000 0", pred_valid_o, pred_pc_o, ckpt_cnt_o);
      end
      drive_op(JAL, 5'd1, 5'd0, 32'hA0);
      drive_op(JAL, 5'd5, 5'd0, 32'hB0);
      drive_op(JALR, 5'd0, 5'd1, 32'hC0);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o} !== {1'b1, 32'hB4}) begin
         err_cnt++;
         $display("FAIL b2b_pop1 got v=%b pc=%h exp 1 000000b4", pred_valid_o, pred_pc_o);
      end
      drive_op(JALR, 5'd0, 5'd1, 32'hD0);
      vec_cnt++;
      if ({pred_valid_o, pred_pc_o, empty_o, unf_o} !== {1'b1, 32'hA4, 1'b1, 1'b0}) begin
         err_cnt++;
         $display("FAIL b2b_pop2 got v=%b pc=%h empty=%b unf=%b exp 1 000000a4 1 0",
                  pred_valid_o, pred_pc_o, empty_o, unf_o);
      end
   endtask

   initial begin
      test_reset();
      test_call_return();
      test_overflow();
      test_coroutine();
      test_restore();
      test_reset_with_push();
      test_no_action();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
